// File: rtl/spi_flash_monitor.sv
// rtl/spi_flash_monitor.sv - passive SPI flash bus snooper with command decode, op counters and status colour
//
// Purpose: listens to the ESP-to-flash passthrough bus without driving it, decodes
// each command, counts completed page programs and erases, tracks the flash WIP bit
// from status reads and produces a GRB colour for the WS2812B driver plus an
// activity flag for the restart logic.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   spi_sck      snooped SPI clock (mode 0)
//   spi_cs_n     snooped chip select, active low
//   spi_mosi     snooped ESP-to-flash data
//   spi_miso     snooped flash-to-ESP data
//   opcode       last decoded command byte
//   opcode_valid one-cycle pulse when opcode updates
//   pp_count     completed page programs, saturating
//   erase_count  completed erase commands, saturating
//   flash_busy   last observed WIP bit
//   activity     bus activity indicator
//   led_color    GRB status colour
module spi_flash_monitor #(
  parameter int CLOCK_MHZ   = 27,
  parameter int ACTIVITY_MS = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  input  logic        spi_miso,
  output logic [7:0]  opcode,
  output logic        opcode_valid,
  output logic [15:0] pp_count,
  output logic [15:0] erase_count,
  output logic        flash_busy,
  output logic        activity,
  output logic [23:0] led_color
);

  localparam int SYNC_N     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TIMER_LOAD = CLOCK_MHZ * 1000 * ACTIVITY_MS;
  localparam int TW         = $clog2(TIMER_LOAD + 1);
  localparam logic [TW-1:0] TIMER_LOAD_V = TW'(TIMER_LOAD);

  localparam logic [23:0] LED_RED    = 24'h00FF00;
  localparam logic [23:0] LED_PURPLE = 24'h007F7F;
  localparam logic [23:0] LED_BLUE   = 24'h0000FF;
  localparam logic [23:0] LED_GREEN  = 24'hFF0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DATA,
    ST_STATUS
  } state_t;

  // Input synchronisers; cs_n resets high so the bus looks deselected.
  logic [SYNC_N-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, miso_sync_q;
  logic              sck_prev_q, cs_prev_q;
  logic              sck_s, cs_s, mosi_s, miso_s;
  logic              sck_rise, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      miso_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_N-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_N-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_N-2:0], spi_mosi};
      miso_sync_q <= {miso_sync_q[SYNC_N-2:0], spi_miso};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_N-1];
  assign cs_s     = cs_sync_q[SYNC_N-1];
  assign mosi_s   = mosi_sync_q[SYNC_N-1];
  assign miso_s   = miso_sync_q[SYNC_N-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // Decoder state
  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  cmd_q, cmd_d;        // opcode of the current transaction, 0 until complete
  logic        addr_done_q, addr_done_d;
  logic        data_seen_q, data_seen_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic        op_latch, status_latch;
  logic [7:0]  shift_mosi, shift_miso;

  // Output / status state
  logic [7:0]  opcode_q;
  logic        opcode_valid_q;
  logic [15:0] pp_count_q, erase_count_q;
  logic        flash_busy_q;
  logic        last_erase_q;
  logic        commit_pp, commit_erase;

  // Effect of this cycle's SCK sample. The commit logic below looks at these
  // next-state values so a sample landing with cs_n rising is counted first.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    cmd_d        = cmd_q;
    addr_done_d  = addr_done_q;
    data_seen_d  = data_seen_q;
    byte_cnt_d   = byte_cnt_q;
    op_latch     = 1'b0;
    status_latch = 1'b0;
    shift_mosi   = {shift_q[6:0], mosi_s};
    shift_miso   = {shift_q[6:0], miso_s};
    if (sck_rise) begin
      case (state_q)
        ST_OPCODE: begin
          shift_d = shift_mosi;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            cmd_d     = shift_mosi;
            op_latch  = 1'b1;
            case (shift_mosi)
              8'h02, 8'h20, 8'h52, 8'hD8, 8'h03, 8'h0B: state_d = ST_ADDR;
              8'h05:                                    state_d = ST_STATUS;
              default:                                  state_d = ST_DATA;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_ADDR: begin
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d   = '0;
            addr_done_d = 1'b1;
            state_d     = ST_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_DATA: begin
          data_seen_d = 1'b1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_STATUS: begin
          shift_d = shift_miso;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d    = '0;
            status_latch = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    commit_pp    = 1'b0;
    commit_erase = 1'b0;
    if (cs_rise) begin
      case (cmd_d)
        8'h02:               commit_pp    = addr_done_d && (byte_cnt_d != 8'd0);
        8'h20, 8'h52, 8'hD8: commit_erase = addr_done_d && !data_seen_d;
        8'h60, 8'hC7:        commit_erase = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      cmd_q          <= '0;
      addr_done_q    <= 1'b0;
      data_seen_q    <= 1'b0;
      byte_cnt_q     <= '0;
      opcode_q       <= '0;
      opcode_valid_q <= 1'b0;
      pp_count_q     <= '0;
      erase_count_q  <= '0;
      flash_busy_q   <= 1'b0;
      last_erase_q   <= 1'b0;
    end else begin
      opcode_valid_q <= op_latch;
      if (op_latch) opcode_q <= shift_d;
      if (status_latch) flash_busy_q <= shift_d[0];
      if (cs_rise) begin
        state_q <= ST_IDLE;
        if (commit_pp) begin
          if (pp_count_q != 16'hFFFF) pp_count_q <= pp_count_q + 16'd1;
          last_erase_q <= 1'b0;
        end
        if (commit_erase) begin
          if (erase_count_q != 16'hFFFF) erase_count_q <= erase_count_q + 16'd1;
          last_erase_q <= 1'b1;
        end
      end else if (state_q == ST_IDLE) begin
        if (cs_fall) begin
          state_q     <= ST_OPCODE;
          bit_cnt_q   <= '0;
          shift_q     <= '0;
          cmd_q       <= '0;
          addr_done_q <= 1'b0;
          data_seen_q <= 1'b0;
          byte_cnt_q  <= '0;
        end
      end else begin
        state_q     <= state_d;
        bit_cnt_q   <= bit_cnt_d;
        shift_q     <= shift_d;
        cmd_q       <= cmd_d;
        addr_done_q <= addr_done_d;
        data_seen_q <= data_seen_d;
        byte_cnt_q  <= byte_cnt_d;
      end
    end
  end

  // Activity hold-off timer: reloads when cs_n rises, drains while deselected.
  logic [TW-1:0] timer_q, timer_d;
  logic          activity_q, activity_d;
  logic [23:0]   led_color_q, led_color_d;

  always_comb begin
    timer_d = timer_q;
    if (cs_rise) begin
      timer_d = TIMER_LOAD_V;
    end else if (cs_s && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end
    activity_d = ~cs_s | (timer_d != '0);
  end

  always_comb begin
    if (flash_busy_q && last_erase_q) begin
      led_color_d = LED_RED;
    end else if (flash_busy_q) begin
      led_color_d = LED_PURPLE;
    end else if (activity_q) begin
      led_color_d = LED_BLUE;
    end else begin
      led_color_d = LED_GREEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      activity_q  <= 1'b0;
      led_color_q <= LED_GREEN;
    end else begin
      timer_q     <= timer_d;
      activity_q  <= activity_d;
      led_color_q <= led_color_d;
    end
  end

  assign opcode       = opcode_q;
  assign opcode_valid = opcode_valid_q;
  assign pp_count     = pp_count_q;
  assign erase_count  = erase_count_q;
  assign flash_busy   = flash_busy_q;
  assign activity     = activity_q;
  assign led_color    = led_color_q;

endmodule

// File: tb/tb_spi_flash_monitor.sv
// tb/tb_spi_flash_monitor.sv - directed self-checking bench for spi_flash_monitor
module tb_spi_flash_monitor;

  localparam int CLK_MHZ = 2;
  localparam int ACT_MS  = 1;
  localparam int LOAD    = CLK_MHZ * 1000 * ACT_MS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso = 1'b0;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic [15:0] pp_count;
  logic [15:0] erase_count;
  logic        flash_busy;
  logic        activity;
  logic [23:0] led_color;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  spi_flash_monitor #(
    .CLOCK_MHZ  (CLK_MHZ),
    .ACTIVITY_MS(ACT_MS),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (sck),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .opcode      (opcode),
    .opcode_valid(opcode_valid),
    .pp_count    (pp_count),
    .erase_count (erase_count),
    .flash_busy  (flash_busy),
    .activity    (activity),
    .led_color   (led_color)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (opcode_valid) pulses++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: data changes while SCK is low, SCK = clk/8.
  task automatic spi_byte(input logic [7:0] mo, input logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      miso = mi[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low;
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high;
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    total++; if (opcode !== 8'h00) begin bad++; $display("FAIL rst_opcode: got %h want %h", opcode, 8'h00); end
    total++; if (opcode_valid !== 1'b0) begin bad++; $display("FAIL rst_opvalid: got %b want 0", opcode_valid); end
    total++; if ({pp_count, erase_count} !== 32'h0) begin bad++; $display("FAIL rst_counts: got %h want 0", {pp_count, erase_count}); end
    total++; if ({flash_busy, activity} !== 2'b00) begin bad++; $display("FAIL rst_busy_act: got %b want 00", {flash_busy, activity}); end
    total++; if (led_color !== 24'hFF0000) begin bad++; $display("FAIL rst_led: got %h want FF0000", led_color); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_page_program;
    int p0;
    int hi;
    p0 = pulses;
    cs_low();
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h10, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'hA5, 8'h00);
    spi_byte(8'h5A, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'hFF, 8'h00);
    tick(4);
    cs_n = 1'b1;
    hi = 0;
    for (int i = 0; i < LOAD + 50; i++) begin
      @(negedge clk);
      if (activity) hi++;
    end
    total++; if (opcode !== 8'h02) begin bad++; $display("FAIL pp_opcode: got %h want 02", opcode); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL pp_pulses: got %0d want 1", pulses - p0); end
    total++; if (pp_count !== 16'd1) begin bad++; $display("FAIL pp_count: got %h want 0001", pp_count); end
    total++; if (erase_count !== 16'd0) begin bad++; $display("FAIL pp_erase: got %h want 0000", erase_count); end
    total++; if (hi < LOAD + 1 || hi > LOAD + 3) begin bad++; $display("FAIL pp_activity_len: got %0d want %0d..%0d", hi, LOAD + 1, LOAD + 3); end
    total++; if (led_color !== 24'hFF0000) begin bad++; $display("FAIL pp_led_idle: got %h want FF0000", led_color); end
  endtask

  task automatic test_erase_status;
    cs_low();
    spi_byte(8'h20, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h10, 8'h00);
    spi_byte(8'h00, 8'h00);
    cs_high();
    total++; if (erase_count !== 16'd1) begin bad++; $display("FAIL se_count: got %h want 0001", erase_count); end
    cs_low();
    spi_byte(8'h05, 8'h00);
    spi_byte(8'h00, 8'h03);
    tick(4);
    total++; if (flash_busy !== 1'b1) begin bad++; $display("FAIL st_busy1: got %b want 1", flash_busy); end
    total++; if (led_color !== 24'h00FF00) begin bad++; $display("FAIL st_led_red: got %h want 00FF00", led_color); end
    spi_byte(8'h00, 8'h03);
    tick(4);
    total++; if (flash_busy !== 1'b1) begin bad++; $display("FAIL st_busy2: got %b want 1", flash_busy); end
    spi_byte(8'h00, 8'h00);
    tick(4);
    total++; if (flash_busy !== 1'b0) begin bad++; $display("FAIL st_busy3: got %b want 0", flash_busy); end
    cs_high();
    total++; if (led_color !== 24'h0000FF) begin bad++; $display("FAIL st_led_blue: got %h want 0000FF", led_color); end
    total++; if (opcode !== 8'h05) begin bad++; $display("FAIL st_opcode: got %h want 05", opcode); end
  endtask

  task automatic test_aborted;
    int p0;
    cs_low();
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h10, 8'h00);
    cs_high();
    total++; if (pp_count !== 16'd1) begin bad++; $display("FAIL ab_pp_short: got %h want 0001", pp_count); end
    cs_low();
    spi_byte(8'h20, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h10, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'hFF, 8'h00);
    cs_high();
    total++; if (erase_count !== 16'd1) begin bad++; $display("FAIL ab_erase_extra: got %h want 0001", erase_count); end
    p0 = pulses;
    cs_n = 1'b0;
    tick(6);
    cs_n = 1'b1;
    tick(6);
    total++; if ({pulses - p0, opcode, pp_count, erase_count} !== {32'd0, 8'h20, 16'd1, 16'd1}) begin
      bad++; $display("FAIL ab_glitch: got pulses=%0d op=%h pp=%h er=%h want 0 20 0001 0001", pulses - p0, opcode, pp_count, erase_count);
    end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    force dut.erase_count_q = 16'hFFFE;
    tick(1);
    release dut.erase_count_q;
    cs_low();
    spi_byte(8'hC7, 8'h00);
    cs_high();
    total++; if (erase_count !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h want FFFF", erase_count); end
    cs_low();
    spi_byte(8'hC7, 8'h00);
    cs_high();
    total++; if (erase_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want FFFF", erase_count); end
    total++; if (pp_count !== 16'd1) begin bad++; $display("FAIL sat_pp: got %h want 0001", pp_count); end
  endtask

  task automatic test_reset_mid;
    cs_low();
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (opcode !== 8'h00) begin bad++; $display("FAIL mid_opcode: got %h want 00", opcode); end
    total++; if ({pp_count, erase_count} !== 32'h0) begin bad++; $display("FAIL mid_counts: got %h want 0", {pp_count, erase_count}); end
    total++; if ({opcode_valid, flash_busy, activity} !== 3'b000) begin bad++; $display("FAIL mid_flags: got %b want 000", {opcode_valid, flash_busy, activity}); end
    total++; if (led_color !== 24'hFF0000) begin bad++; $display("FAIL mid_led: got %h want FF0000", led_color); end
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_wren;
    int p0;
    p0 = pulses;
    cs_low();
    spi_byte(8'h06, 8'h00);
    cs_high();
    total++; if (opcode !== 8'h06) begin bad++; $display("FAIL wren_opcode: got %h want 06", opcode); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL wren_pulses: got %0d want 1", pulses - p0); end
    total++; if ({pp_count, erase_count} !== 32'h0) begin bad++; $display("FAIL wren_counts: got %h want 0", {pp_count, erase_count}); end
    total++; if (activity !== 1'b1) begin bad++; $display("FAIL wren_act: got %b want 1", activity); end
    total++; if (led_color !== 24'h0000FF) begin bad++; $display("FAIL wren_led_blue: got %h want 0000FF", led_color); end
    tick(LOAD + 20);
    total++; if (activity !== 1'b0) begin bad++; $display("FAIL wren_act_expire: got %b want 0", activity); end
    total++; if (led_color !== 24'hFF0000) begin bad++; $display("FAIL wren_led_green: got %h want FF0000", led_color); end
  endtask

  initial begin
    test_reset();
    test_page_program();
    test_erase_status();
    test_aborted();
    test_saturation();
    test_reset_mid();
    test_wren();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
